// File: rtl/rc_failsafe_pkg.sv
// Shared types and defaults for the RC arming / link-loss supervisor.
package rc_failsafe_pkg;

    typedef enum logic [1:0] {
        ST_DISARMED = 2'd0,
        ST_ARMED    = 2'd1,
        ST_DESCENT  = 2'd2,
        ST_LOCKOUT  = 2'd3
    } fs_state_t;

    localparam int unsigned RC_TIMEOUT_US = 50000;
    localparam int          WD_CNT_W      = 17;
    localparam int          HOLD_CNT_W    = 20;

endpackage

// File: rtl/rc_link_watchdog.sv
// One RC channel activity monitor: synchronise the raw pulse, detect rising
// edges and flag the channel stale once TIMEOUT_US ticks pass without one.
module rc_link_watchdog
    import rc_failsafe_pkg::*;
#(
    parameter int unsigned TIMEOUT_US = RC_TIMEOUT_US
) (
    input  logic us_clk,
    input  logic resetn,
    input  logic pwm_in,
    output logic chan_ok
);

    localparam logic [WD_CNT_W-1:0] LIMIT = WD_CNT_W'(TIMEOUT_US);

    // [0],[1] form the synchroniser; [2] is the previous synchronised level.
    logic [2:0]          sync_q;
    logic [WD_CNT_W-1:0] idle_cnt;
    logic                rise;

    assign rise    = sync_q[1] & ~sync_q[2];
    assign chan_ok = (idle_cnt < LIMIT);

    // Preloading to LIMIT keeps the channel reading stale until a real edge.
    always_ff @(posedge us_clk or negedge resetn) begin
        if (!resetn) begin
            sync_q   <= 3'b000;
            idle_cnt <= LIMIT;
        end else begin
            sync_q <= {sync_q[1:0], pwm_in};
            if (rise) begin
                idle_cnt <= '0;
            end else if (idle_cnt < LIMIT) begin
                idle_cnt <= idle_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/rc_failsafe.sv
// Arming and link-loss supervisor sitting between the receiver and the
// angle controller; all outputs are registered from the current state.
module rc_failsafe
    import rc_failsafe_pkg::*;
#(
    parameter int unsigned                    REC_VAL_BIT_WIDTH = 8,
    parameter int unsigned                    TIMEOUT_US        = RC_TIMEOUT_US,
    parameter int unsigned                    ARM_HOLD_US       = 500000,
    parameter logic [REC_VAL_BIT_WIDTH-1:0]   THR_LOW           = 8'd10,
    parameter logic [REC_VAL_BIT_WIDTH-1:0]   YAW_ARM           = 8'd240,
    parameter logic [REC_VAL_BIT_WIDTH-1:0]   YAW_DISARM        = 8'd15,
    parameter logic [REC_VAL_BIT_WIDTH-1:0]   CENTER            = 8'd128,
    parameter logic [REC_VAL_BIT_WIDTH-1:0]   FS_THROTTLE       = 8'd90,
    parameter int unsigned                    DESCENT_STEP_US   = 20000
) (
    input  logic                         us_clk,
    input  logic                         resetn,
    input  logic                         throttle_pwm,
    input  logic                         yaw_pwm,
    input  logic                         roll_pwm,
    input  logic                         pitch_pwm,
    input  logic [REC_VAL_BIT_WIDTH-1:0] throttle_val,
    input  logic [REC_VAL_BIT_WIDTH-1:0] yaw_val,
    input  logic [REC_VAL_BIT_WIDTH-1:0] roll_val,
    input  logic [REC_VAL_BIT_WIDTH-1:0] pitch_val,
    output logic [REC_VAL_BIT_WIDTH-1:0] throttle_out,
    output logic [REC_VAL_BIT_WIDTH-1:0] yaw_out,
    output logic [REC_VAL_BIT_WIDTH-1:0] roll_out,
    output logic [REC_VAL_BIT_WIDTH-1:0] pitch_out,
    output logic                         armed,
    output logic                         failsafe_active,
    output logic                         link_ok,
    output logic [1:0]                   fs_state
);

    localparam logic [HOLD_CNT_W-1:0] HOLD_LAST = HOLD_CNT_W'(ARM_HOLD_US - 1);
    localparam logic [HOLD_CNT_W-1:0] STEP_LAST = HOLD_CNT_W'(DESCENT_STEP_US - 1);

    logic [3:0]                   chan_ok;
    fs_state_t                    state;
    logic [HOLD_CNT_W-1:0]        gest_cnt;
    logic [HOLD_CNT_W-1:0]        step_cnt;
    logic [REC_VAL_BIT_WIDTH-1:0] desc_thr;
    logic                         thr_low;
    logic                         gesture;
    logic                         hold_done;

    rc_link_watchdog #(.TIMEOUT_US(TIMEOUT_US)) u_wd_throttle (
        .us_clk(us_clk), .resetn(resetn), .pwm_in(throttle_pwm), .chan_ok(chan_ok[0]));
    rc_link_watchdog #(.TIMEOUT_US(TIMEOUT_US)) u_wd_yaw (
        .us_clk(us_clk), .resetn(resetn), .pwm_in(yaw_pwm), .chan_ok(chan_ok[1]));
    rc_link_watchdog #(.TIMEOUT_US(TIMEOUT_US)) u_wd_roll (
        .us_clk(us_clk), .resetn(resetn), .pwm_in(roll_pwm), .chan_ok(chan_ok[2]));
    rc_link_watchdog #(.TIMEOUT_US(TIMEOUT_US)) u_wd_pitch (
        .us_clk(us_clk), .resetn(resetn), .pwm_in(pitch_pwm), .chan_ok(chan_ok[3]));

    always_ff @(posedge us_clk or negedge resetn) begin
        if (!resetn) begin
            link_ok <= 1'b0;
        end else begin
            link_ok <= &chan_ok;
        end
    end

    assign thr_low = (throttle_val <= THR_LOW);

    // Only one gesture is meaningful per state, so a single hold timer serves all.
    always_comb begin
        gesture = 1'b0;
        case (state)
            ST_DISARMED: gesture = link_ok && thr_low && (yaw_val >= YAW_ARM);
            ST_ARMED:    gesture = thr_low && (yaw_val <= YAW_DISARM);
            ST_LOCKOUT:  gesture = link_ok && thr_low;
            default:     gesture = 1'b0;
        endcase
        hold_done = gesture && (gest_cnt == HOLD_LAST);
    end

    always_ff @(posedge us_clk or negedge resetn) begin
        if (!resetn) begin
            state           <= ST_DISARMED;
            gest_cnt        <= '0;
            step_cnt        <= '0;
            desc_thr        <= '0;
            throttle_out    <= '0;
            yaw_out         <= CENTER;
            roll_out        <= CENTER;
            pitch_out       <= CENTER;
            armed           <= 1'b0;
            failsafe_active <= 1'b0;
            fs_state        <= ST_DISARMED;
        end else begin
            throttle_out    <= '0;
            yaw_out         <= CENTER;
            roll_out        <= CENTER;
            pitch_out       <= CENTER;
            armed           <= (state == ST_ARMED);
            failsafe_active <= (state == ST_DESCENT) || (state == ST_LOCKOUT);
            fs_state        <= state;
            if (state == ST_ARMED) begin
                throttle_out <= throttle_val;
                yaw_out      <= yaw_val;
                roll_out     <= roll_val;
                pitch_out    <= pitch_val;
            end else if (state == ST_DESCENT) begin
                throttle_out <= desc_thr;
            end

            gest_cnt <= (!gesture || hold_done) ? '0 : gest_cnt + 1'b1;

            case (state)
                ST_DISARMED: if (hold_done) state <= ST_ARMED;
                ST_ARMED: begin
                    // Link loss outranks a disarm gesture completing on the same tick.
                    if (!link_ok) begin
                        state    <= ST_DESCENT;
                        gest_cnt <= '0;
                        step_cnt <= '0;
                        desc_thr <= (throttle_out < FS_THROTTLE) ? throttle_out : FS_THROTTLE;
                    end else if (hold_done) begin
                        state <= ST_DISARMED;
                    end
                end
                ST_DESCENT: begin
                    if (desc_thr == '0) begin
                        state    <= ST_LOCKOUT;
                        gest_cnt <= '0;
                    end else if (step_cnt == STEP_LAST) begin
                        step_cnt <= '0;
                        desc_thr <= desc_thr - 1'b1;
                    end else begin
                        step_cnt <= step_cnt + 1'b1;
                    end
                end
                ST_LOCKOUT: if (hold_done) state <= ST_DISARMED;
                default: state <= ST_DISARMED;
            endcase
        end
    end

endmodule
